// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses A5/CMD/ARG/CHK frames from the UART RX stream,
// updates LED / seven-segment registers and returns a one-byte response.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] led,
  output logic [3:0] seg_digit,
  output logic       seg_en,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] OP_SET_DIGIT = 8'h01;
  localparam logic [7:0] OP_SET_LED   = 8'h02;
  localparam logic [7:0] OP_GET_LED   = 8'h03;
  localparam logic [7:0] OP_CLR_ERR   = 8'h04;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GOT_HDR = 3'd1,
    GOT_CMD = 3'd2,
    GOT_ARG = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg_q, arg_d;
  logic [7:0]       led_q, led_d;
  logic [3:0]       seg_digit_q, seg_digit_d;
  logic             seg_en_q, seg_en_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             err_inc, err_clr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    led_d       = led_q;
    seg_digit_d = seg_digit_q;
    seg_en_d    = seg_en_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    err_inc     = 1'b0;
    err_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_valid && rx_data == HDR) state_d = GOT_HDR;
      end
      GOT_HDR, GOT_CMD, GOT_ARG: begin
        // An arriving byte beats the timeout in the expiry cycle.
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == GOT_HDR) begin
            cmd_d   = rx_data;
            state_d = GOT_CMD;
          end else if (state_q == GOT_CMD) begin
            arg_d   = rx_data;
            state_d = GOT_ARG;
          end else begin
            state_d    = RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = NAK;
            if (rx_data != (cmd_q ^ arg_q)) begin
              err_inc = 1'b1;
            end else begin
              case (cmd_q)
                OP_SET_DIGIT: begin
                  seg_digit_d = arg_q[3:0];
                  seg_en_d    = arg_q[7];
                  tx_data_d   = ACK;
                end
                OP_SET_LED: begin
                  led_d     = arg_q;
                  tx_data_d = ACK;
                end
                OP_GET_LED: tx_data_d = led_q;
                OP_CLR_ERR: begin
                  err_clr   = 1'b1;
                  tx_data_d = ACK;
                end
                default: err_inc = 1'b1;
              endcase
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          err_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (err_clr)                      err_d = 8'h00;
    else if (err_inc && err_q != 8'hFF) err_d = err_q + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= 8'h00;
      arg_q       <= 8'h00;
      led_q       <= 8'h00;
      seg_digit_q <= 4'h0;
      seg_en_q    <= 1'b0;
      err_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      led_q       <= led_d;
      seg_digit_q <= seg_digit_d;
      seg_en_q    <= seg_en_d;
      err_q       <= err_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign led       = led_q;
  assign seg_digit = seg_digit_q;
  assign seg_en    = seg_en_q;
  assign err_count = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus hand-built timeout,
// backpressure, saturation and reset sequences.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] led;
  logic [3:0] seg_digit;
  logic       seg_en;
  logic [7:0] err_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led(led), .seg_digit(seg_digit), .seg_en(seg_en),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [7:0] chk;
    logic [7:0] exp_tx;
    logic [7:0] exp_led;
    logic [3:0] exp_digit;
    logic       exp_en;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one strobe at a negedge; returns at the negedge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(k);
  endtask

  task automatic finish_resp(input string name);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check({name, "_txv_after"}, 32'(tx_valid), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h02, 8'h3C, 8'h3E, 8'h06, 8'h3C, 4'h0, 1'b0, 8'd0};
    vecs[1] = '{8'h01, 8'h85, 8'h00, 8'h15, 8'h3C, 4'h0, 1'b0, 8'd1};
    vecs[2] = '{8'h01, 8'h85, 8'h84, 8'h06, 8'h3C, 4'h5, 1'b1, 8'd1};
    vecs[3] = '{8'h03, 8'h00, 8'h03, 8'h3C, 8'h3C, 4'h5, 1'b1, 8'd1};
    vecs[4] = '{8'h07, 8'h11, 8'h16, 8'h15, 8'h3C, 4'h5, 1'b1, 8'd2};
    vecs[5] = '{8'h04, 8'h00, 8'h04, 8'h06, 8'h3C, 4'h5, 1'b1, 8'd0};
    vecs[6] = '{8'h02, 8'hFF, 8'hFD, 8'h06, 8'hFF, 4'h5, 1'b1, 8'd0};
    vecs[7] = '{8'h01, 8'h0A, 8'h0B, 8'h06, 8'hFF, 4'hA, 1'b0, 8'd0};

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_led", 32'(led), 32'h00);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txd", 32'(tx_data), 32'h00);
    check("rst_err", 32'(err_count), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);

    send_byte(8'h3C);
    check("idle_garbage_busy", 32'(busy), 32'd0);
    check("idle_garbage_err", 32'(err_count), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].cmd, vecs[i].arg, vecs[i].chk);
      $display("vec %0d: cmd=%02h arg=%02h chk=%02h -> tx=%02h led=%02h dig=%0h en=%0b err=%0d",
               i, vecs[i].cmd, vecs[i].arg, vecs[i].chk, tx_data, led, seg_digit, seg_en, err_count);
      check($sformatf("v%0d_txv", i), 32'(tx_valid), 32'd1);
      check($sformatf("v%0d_txd", i), 32'(tx_data), 32'(vecs[i].exp_tx));
      check($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("v%0d_dig", i), 32'(seg_digit), 32'(vecs[i].exp_digit));
      check($sformatf("v%0d_en", i), 32'(seg_en), 32'(vecs[i].exp_en));
      check($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
      finish_resp($sformatf("v%0d", i));
    end

    // Timeout: 16 silent cycles after CMD abort the frame.
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (15) @(negedge clk);
    check("to_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    $display("timeout: busy=%0b txv=%0b err=%0d", busy, tx_valid, err_count);
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_txv", 32'(tx_valid), 32'd0);
    check("to_err", 32'(err_count), 32'd1);

    // Race: a byte in the expiry cycle is accepted.
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (14) @(negedge clk);
    send_byte(8'h55);
    check("race_busy", 32'(busy), 32'd1);
    check("race_err", 32'(err_count), 32'd1);
    send_byte(8'h57);
    $display("race: txv=%0b txd=%02h led=%02h err=%0d", tx_valid, tx_data, led, err_count);
    check("race_txd", 32'(tx_data), 32'h06);
    check("race_led", 32'(led), 32'h55);
    finish_resp("race");

    // Backpressure on GET_LED with stray RX bytes.
    send_frame(8'h03, 8'h00, 8'h03);
    for (int c = 0; c < 50; c++) begin
      rx_data  = 8'hA5;
      rx_valid = (c % 7 == 3);
      @(negedge clk);
      check($sformatf("bp_txd_%0d", c), 32'(tx_data), 32'h55);
      check($sformatf("bp_txv_%0d", c), 32'(tx_valid), 32'd1);
    end
    rx_valid = 1'b0;
    $display("backpressure: txd=%02h held 50 cycles", tx_data);
    finish_resp("bp");

    // Saturation.
    for (int f = 0; f < 300; f++) begin
      send_frame(8'h01, 8'h85, 8'h00);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    $display("saturation: err=%0d", err_count);
    check("sat_err", 32'(err_count), 32'd255);
    send_frame(8'h04, 8'h00, 8'h04);
    $display("clr_err: txd=%02h err=%0d", tx_data, err_count);
    check("clr_txd", 32'(tx_data), 32'h06);
    check("clr_err", 32'(err_count), 32'd0);
    finish_resp("clr");

    // Reset mid-frame.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("midreset: led=%02h busy=%0b txv=%0b err=%0d", led, busy, tx_valid, err_count);
    check("mr_led", 32'(led), 32'h00);
    check("mr_dig", 32'(seg_digit), 32'h0);
    check("mr_en", 32'(seg_en), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_txv", 32'(tx_valid), 32'd0);
    check("mr_txd", 32'(tx_data), 32'h00);
    check("mr_err", 32'(err_count), 32'h00);
    send_frame(8'h02, 8'h81, 8'h83);
    $display("post-reset frame: txd=%02h led=%02h", tx_data, led);
    check("pr_txd", 32'(tx_data), 32'h06);
    check("pr_led", 32'(led), 32'h81);
    finish_resp("pr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter and the LED / seven-segment output registers of the UART-LED design.
- Parses 4-byte command frames from the RX byte stream, validates checksum and opcode, and updates the display/LED registers.
- Returns a one-byte response to the TX path through a valid/ready handshake.
- Counts framing errors and aborts stalled frames via an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, 100000, max clk cycles allowed between bytes inside a frame before abort (≥2).
- CNT_W, 17, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  single-cycle strobe, one per received byte
- tx_data  out  8  response byte
- tx_valid  out  1  response available; held until accepted
- tx_ready  in  1  TX path accepts tx_data when tx_valid & tx_ready
- led  out  8  LED register
- seg_digit  out  4  hex digit shown on seven-segment (decoder is external)
- seg_en  out  1  seven-segment enable
- err_count  out  8  saturating error counter
- busy  out  1  high in any state other than IDLE

Behaviour:
- Frame: HDR=0xA5, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- Opcodes:
  - 0x01 SET_DIGIT: seg_digit<=ARG[3:0], seg_en<=ARG[7]; resp 0x06.
  - 0x02 SET_LED: led<=ARG; resp 0x06.
  - 0x03 GET_LED: no update; resp = current led.
  - 0x04 CLR_ERR: err_count<=0; resp 0x06.
  - Any other opcode: NAK 0x15.
- FSM states: IDLE, GOT_HDR, GOT_CMD, GOT_ARG, RESP.
  - IDLE: rx_valid & rx_data==0xA5 -> GOT_HDR. Other bytes are silently ignored (no error).
  - GOT_HDR: rx_valid -> latch CMD, -> GOT_CMD. 0xA5 here is taken as a CMD value, not a resync.
  - GOT_CMD: rx_valid -> latch ARG, -> GOT_ARG.
  - GOT_ARG: rx_valid -> evaluate the CHK byte, -> RESP. On that same edge:
    - register updates apply;
    - tx_data is loaded and tx_valid goes to 1.
  - Net effect: outputs change one cycle after the CHK strobe cycle.
  - RESP: tx_valid=1 and tx_data stable until a cycle with tx_ready=1; on that edge tx_valid<=0, -> IDLE. rx_valid during RESP is dropped.
- Errors:
  - Bad checksum: NAK, no register update, err_count+1.
  - Unknown opcode with good checksum: NAK, err_count+1.
  - Checksum is checked first; any bad CHK gives a single increment.
- Timeout:
  - Counter clears on every accepted byte and counts in GOT_HDR/GOT_CMD/GOT_ARG.
  - When it reaches TIMEOUT_CYCLES-1 with rx_valid=0: -> IDLE, no response, err_count+1.
  - rx_valid in the expiry cycle wins: the byte is accepted and there is no timeout.
  - The counter does not run in IDLE or RESP, so RESP can stall indefinitely on tx_ready.
- err_count saturates at 255; further errors are ignored.
- CLR_ERR takes precedence over any increment in the same cycle (none possible by construction).
- Reset values:
  - led=0x00, seg_digit=0x0, seg_en=0, err_count=0x00;
  - tx_valid=0, tx_data=0x00, busy=0;
  - state=IDLE, timeout counter=0.
- Reset mid-frame or mid-RESP abandons the frame with no response and no error count.
- busy is combinational from state.

Test Plan:
- SET_LED: bytes A5,02,3C,3E (one strobe each, idle gaps) -> led=0x3C the cycle after the 4th strobe, tx_valid=1 with tx_data=0x06. tx_ready pulse -> tx_valid=0, busy=0.
- Bad checksum: A5,01,85,00 -> tx_data=0x15, seg_digit/seg_en unchanged, err_count=1. Then A5,01,85,84 -> seg_digit=5, seg_en=1, resp 0x06.
- Timeout with TIMEOUT_CYCLES=16: A5,02 then no bytes for 16 cycles -> busy drops, no tx_valid, err_count+1.
- Timeout race: a byte arriving exactly in the expiry cycle is accepted instead.
- Backpressure and saturation:
  - GET_LED (A5,03,00,03) with tx_ready held 0 for 50 cycles -> tx_data=led held stable. Extra rx bytes are ignored; the response completes when tx_ready=1.
  - 300 bad frames -> err_count=255. CLR_ERR (A5,04,00,04) -> err_count=0, resp 0x06.
- Sync reset: assert rst after A5,02,FF -> all outputs at reset values. A following full frame (A5,02,81,83) works normally -> led=0x81.
